// File: rtl/int_divider_seq.sv
// Sequential restoring radix-2 integer divider, signed or unsigned, one quotient bit per cycle.
// Results are registered on entry to DONE and held until the next DONE.
module int_divider_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             overflow_q, overflow_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             unused_rem_msb;

  // Signs are pre-gated by signed_mode, so unsigned operations never negate anything.
  assign dvd_neg = signed_mode & dividend[WIDTH-1];
  assign dvs_neg = signed_mode & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  // The stored remainder is always below the divisor, so its MSB only matters after the shift.
  assign shifted        = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial          = shifted - {1'b0, dvs_q};
  assign unused_rem_msb = rem_q[WIDTH];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    ovf_pend_d  = ovf_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            overflow_d  = 1'b0;
          end else begin
            state_d    = StCalc;
            cnt_d      = '0;
            rem_d      = '0;
            quo_d      = dvd_mag;
            dvs_d      = dvs_mag;
            neg_quo_d  = dvd_neg ^ dvs_neg;
            neg_rem_d  = dvd_neg;
            ovf_pend_d = signed_mode && (dividend == {1'b1, {(WIDTH - 1){1'b0}}}) &&
                         (divisor == '1);
          end
        end
      end
      StCalc: begin
        // quo_q shifts out dividend bits at the top and takes quotient bits in at the bottom.
        rem_d = trial[WIDTH] ? shifted : trial;
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d     = StDone;
        quotient_d  = neg_quo_q ? -quo_q : quo_q;
        remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        dbz_d       = 1'b0;
        overflow_d  = ovf_pend_q;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      ovf_pend_q  <= ovf_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_int_divider_seq.sv
// Directed self-checking bench for int_divider_seq at WIDTH=8.
module tb_int_divider_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       signed_mode;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int n_chk = 0;
  int n_bad = 0;
  int done_cnt = 0;

  int_divider_seq #(
    .WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_mode(signed_mode),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_q"}, quotient, 0);
    check({tag, "_r"}, remainder, 0);
    check({tag, "_dbz"}, div_by_zero, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  // Waits from the current negedge for done; returns negedges counted after the sampling edge.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
  endtask

  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                    input logic sm, input int exp_lat, input logic [7:0] eq,
                    input logic [7:0] er, input logic edbz, input logic eovf);
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; signed_mode = sm;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, busy, 1);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, edbz);
    check({tag, "_ovf"}, overflow, eovf);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    op("u200_7",   8'd200, 8'd7,   1'b0, 10, 8'd28,  8'd4,   1'b0, 1'b0);
    op("s-7_2",    8'hF9,  8'h02,  1'b1, 10, 8'hFD,  8'hFF,  1'b0, 1'b0);
    op("s7_-2",    8'h07,  8'hFE,  1'b1, 10, 8'hFD,  8'h01,  1'b0, 1'b0);
    op("s-128_7",  8'h80,  8'h07,  1'b1, 10, 8'hEE,  8'hFE,  1'b0, 1'b0);
    op("dbz",      8'h55,  8'h00,  1'b1, 1,  8'hFF,  8'h55,  1'b1, 1'b0);
    op("sovf",     8'h80,  8'hFF,  1'b1, 10, 8'h80,  8'h00,  1'b0, 1'b1);
    op("u128_255", 8'h80,  8'hFF,  1'b0, 10, 8'h00,  8'h80,  1'b0, 1'b0);

    // Start held high with new operands during CALC.
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd9; signed_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dividend = 8'd50; divisor = 8'd5;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("busy_start_lat1", lat, 10);
    check("busy_start_q1", quotient, 11);
    check("busy_start_r1", remainder, 1);
    @(negedge clk);
    @(negedge clk);
    check("busy_start_hold", quotient, 11);
    check("busy_start_busy2", busy, 1);
    start = 1'b0;
    lat += 0;
    wait_done(lat);
    check("busy_start_lat2", lat + 2, 11);
    check("busy_start_q2", quotient, 10);
    check("busy_start_r2", remainder, 0);

    // Reset in CALC cycle 4.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7; signed_mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 check_all_zero("midrst");
    done_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    op("u255_16",  8'd255, 8'd16,  1'b0, 10, 8'd15,  8'd15,  1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/int_divider_seq.md
INT_DIVIDER_SEQ -- requirements
Module: int_divider_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal values are 4..32.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), giving the iteration counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-006 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 SHALL have port dividend, input, WIDTH bits: numerator; sampled with start.
REQ-008 SHALL have port divisor, input, WIDTH bits: denominator; sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking that the results are valid.
REQ-011 SHALL have port quotient, output, WIDTH bits: result quotient.
REQ-012 SHALL have port remainder, output, WIDTH bits: result remainder.
REQ-013 SHALL have port div_by_zero, output, 1 bit: the last operation had divisor == 0.
REQ-014 SHALL have port overflow, output, 1 bit: the last operation was signed -2^(WIDTH-1) / -1.

Function
REQ-015 SHALL implement an FSM with the states IDLE, CALC, FIX and DONE.
REQ-016 SHALL, in IDLE with start=1 and divisor!=0, register the operand magnitudes, the operand signs and signed_mode, clear the counter, and go to CALC.
REQ-017 SHALL, in IDLE with start=1 and divisor==0, go directly to DONE and skip CALC and FIX.
REQ-018 SHALL, in CALC, perform one restoring radix-2 step per cycle: shift the partial remainder left by one, bring in the next dividend MSB, trial-subtract the divisor magnitude, and on a non-negative result keep it and set the quotient bit.
REQ-019 SHALL use a partial remainder WIDTH+1 bits wide so that no trial subtraction overflows.
REQ-020 SHALL spend exactly WIDTH cycles in CALC and then go to FIX.
REQ-021 SHALL, in FIX, apply signs when signed_mode=1: negate the quotient if the operand signs differ, and give the remainder the sign of the dividend.
REQ-022 SHALL go from FIX to DONE.
REQ-023 SHALL truncate signed quotients toward zero, so that dividend == quotient*divisor + remainder always holds.
REQ-024 SHALL, in DONE, hold done=1 for exactly one cycle and then return to IDLE.
REQ-025 SHALL give a latency from the start-sampling edge to done of WIDTH+2 cycles on the normal path.
REQ-026 SHALL give a latency from the start-sampling edge to done of 1 cycle on the divide-by-zero path.
REQ-027 SHALL, on divide-by-zero, set quotient to all ones, remainder to the raw dividend and div_by_zero=1, independent of signed_mode.
REQ-028 SHALL, for signed -2^(WIDTH-1) / -1, set quotient to 2^(WIDTH-1) (the natural wrap), remainder to 0 and overflow=1.
REQ-029 SHALL ignore start while busy=1; the operation in flight is not disturbed.
REQ-030 SHALL hold quotient, remainder, div_by_zero and overflow stable from DONE until the next DONE.
REQ-031 SHALL change those result outputs only on entry to DONE.
REQ-032 SHALL accept start in the cycle after DONE (IDLE), allowing back-to-back operations every WIDTH+3 cycles.

Reset
REQ-033 SHALL, on rst_n=0, asynchronously force the state to IDLE.
REQ-034 SHALL, on rst_n=0, asynchronously force busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0 and counter=0.
REQ-035 SHALL, when reset is asserted mid-operation, abandon the operation; no done pulse follows the release of reset.
REQ-036 SHALL release reset cleanly, so that start is honoured from the first rising edge with rst_n=1.

Verification (WIDTH=8)
REQ-037 SHALL cover the unsigned case: dividend=200, divisor=7, signed_mode=0 -> quotient=28, remainder=4, done exactly 10 cycles after start, both flags 0.
REQ-038 SHALL cover the signed case: dividend=0xF9 (-7), divisor=0x02, signed_mode=1 -> quotient=0xFD (-3), remainder=0xFF (-1).
REQ-039 SHALL cover divide-by-zero: dividend=0x55, divisor=0 -> done 1 cycle after start, quotient=0xFF, remainder=0x55, div_by_zero=1.
REQ-040 SHALL cover signed overflow: dividend=0x80, divisor=0xFF, signed_mode=1 -> quotient=0x80, remainder=0x00, overflow=1.
REQ-041 SHALL cover start while busy: start held high with new operands during CALC -> first result unchanged; second operation begins only in the IDLE after DONE.
REQ-042 SHALL cover reset mid-operation: rst_n low in CALC cycle 4 -> all outputs 0 immediately, no done pulse; a following 255/16 gives quotient=15, remainder=15.
